// File: rtl/multiword_add_seq_pkg.sv
// Shared types and sizing helpers for the nibble-serial multiword adder.
// Used by multiword_add_seq and its interface.
package multiword_add_seq_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int calc_nibbles(input int width);
        return width / NIBBLE_W;
    endfunction

    // A single-nibble word would give $clog2 of 1, so keep the index at least one bit wide.
    function automatic int calc_idx_width(input int width);
        return (width / NIBBLE_W > 1) ? $clog2(width / NIBBLE_W) : 1;
    endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// Request/result bundle between a requester and multiword_add_seq.
// The op/ovf pair exists only when MULTIWORD_ADD_SEQ_SUB_EN is defined.
interface multiword_add_seq_if #(parameter int WIDTH = 16);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    logic             op;
    logic             ovf;

    modport master (output start, a, b, cin, op, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, op, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/multiword_add_seq_adder.sv
// Adder_4_Bit: the shared 4-bit ripple-carry slice time-shared by the sequencer.
module Adder_4_Bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/multiword_add_seq.sv
// WIDTH-bit add computed one nibble per clock through a single Adder_4_Bit slice.
// Define MULTIWORD_ADD_SEQ_SUB_EN to add the op (subtract) input and ovf output.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    multiword_add_seq_if.slave  bus
);

    localparam int NIBBLES = calc_nibbles(WIDTH);
    localparam int IDX_W   = calc_idx_width(WIDTH);

    state_t              state_q;
    state_t              state_d;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    logic [WIDTH-1:0]    partial_q;
    logic [WIDTH-1:0]    sum_q;
    logic                carry_q;
    logic                cout_q;
    logic                done_q;
    logic [IDX_W-1:0]    idx_q;
    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                slice_cout;
    logic                accept;
    logic                last;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    logic                ovf_q;
`endif

    assign accept = (state_q == IDLE) && bus.start;
    assign last   = (state_q == RUN) && (idx_q == IDX_W'(NIBBLES - 1));
    assign a_nib  = a_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];
    assign b_nib  = b_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W];

    Adder_4_Bit u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (s_nib),
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == RUN);
        bus.done = done_q;
        bus.sum  = sum_q;
        bus.cout = cout_q;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
        bus.ovf  = ovf_q;
`endif
    end

    // Subtraction is a + ~b + 1: B is inverted once at accept and the carry seeded with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            partial_q <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            done_q    <= 1'b0;
            idx_q     <= '0;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q   <= bus.a;
                idx_q <= '0;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
                b_q     <= bus.op ? ~bus.b : bus.b;
                carry_q <= bus.op | bus.cin;
`else
                b_q     <= bus.b;
                carry_q <= bus.cin;
`endif
            end else if (state_q == RUN) begin
                partial_q[NIBBLE_W*int'(idx_q) +: NIBBLE_W] <= s_nib;
                carry_q <= slice_cout;
                idx_q   <= idx_q + 1'b1;
                if (last) begin
                    sum_q  <= {s_nib, partial_q[WIDTH-NIBBLE_W-1:0]};
                    cout_q <= slice_cout;
                    done_q <= 1'b1;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
                    ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (s_nib[NIBBLE_W-1] != a_q[WIDTH-1]);
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed plus random bench for multiword_add_seq against a plain-arithmetic model.
// Exercises the subtract path too when MULTIWORD_ADD_SEQ_SUB_EN is defined.
module tb_multiword_add_seq;

    localparam int WIDTH   = 16;
    localparam int NIBBLES = WIDTH / 4;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             op_drv;
    logic [WIDTH-1:0] last_sum;
    int               errors = 0;
    int               checks = 0;

    multiword_add_seq_if #(.WIDTH(WIDTH)) bus ();

    multiword_add_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Returns {ovf, cout, sum} from ordinary unsigned/signed integer arithmetic.
    function automatic logic [WIDTH+1:0] refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                  input logic cin, input logic op);
        int unsigned      ua;
        int unsigned      ub;
        int unsigned      full;
        int               sa;
        int               sb;
        int               sr;
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (op) begin
            s  = WIDTH'(ua - ub);
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            full = ua + ub + int'(cin);
            s    = WIDTH'(full);
            c    = (full >= (1 << WIDTH));
            sr   = sa + sb + int'(cin);
        end
        v = (sr > (1 << (WIDTH - 1)) - 1) || (sr < -(1 << (WIDTH - 1)));
        return {v, c, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic c);
        bus.start = s;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = c;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
        bus.op    = op_drv;
`endif
    endtask

    // Waits a bounded number of cycles for done, checking that sum stays frozen meanwhile.
    task automatic waitDone(output int lat, output int busy_cycles);
        lat = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            if (bus.busy === 1'b1) busy_cycles++;
            checkOutput("sum_held", 32'(bus.sum), 32'(last_sum));
            tick();
            lat++;
        end
        checkOutput("done_seen", 32'(bus.done), 32'd1);
    endtask

    task automatic checkResult(input string tag, input logic [WIDTH+1:0] exp);
        checkOutput({tag, "_sum"}, 32'(bus.sum), 32'(exp[WIDTH-1:0]));
        checkOutput({tag, "_cout"}, 32'(bus.cout), 32'(exp[WIDTH]));
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
        checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'(exp[WIDTH+1]));
`endif
        last_sum = exp[WIDTH-1:0];
    endtask

    task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic op);
        logic [WIDTH+1:0] exp;
        int               lat;
        int               busy_cycles;
        op_drv = op;
        exp = refModel(a, b, cin, op);
        applyStimulus(1'b1, a, b, cin);
        tick();
        applyStimulus(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        checkOutput({tag, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
        waitDone(lat, busy_cycles);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(NIBBLES));
        checkOutput({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(NIBBLES));
        checkOutput({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        checkResult(tag, exp);
        tick();
        checkOutput({tag, "_done_pulse_width"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        logic [WIDTH+1:0] exp;
        logic [WIDTH-1:0] pa [6];
        logic [WIDTH-1:0] pb [6];
        logic             pc [6];
        int               lat;
        int               busy_cycles;
        int               done_count;

        op_drv   = 1'b0;
        last_sum = '0;
        rst      = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0);
        repeat (3) tick();
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_sum", 32'(bus.sum), 32'd0);
        checkOutput("reset_cout", 32'(bus.cout), 32'd0);
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
        checkOutput("reset_ovf", 32'(bus.ovf), 32'd0);
`endif
        rst = 1'b0;
        tick();

        runOp("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0);
        checkOutput("tp_5555", 32'(bus.sum), 32'h5555);
        runOp("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        checkOutput("tp_carry_chain_sum", 32'(bus.sum), 32'h0000);
        checkOutput("tp_carry_chain_cout", 32'(bus.cout), 32'd1);

        // A second start two cycles into the run must be ignored.
        op_drv = 1'b0;
        exp = refModel(16'h00FF, 16'h0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h00FF, 16'h0000, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b1, 16'hAAAA, 16'h5555, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        waitDone(lat, busy_cycles);
        checkOutput("ignored_start_latency", 32'(lat), 32'(NIBBLES - 3));
        checkResult("ignored_start", exp);
        checkOutput("tp_0100", 32'(bus.sum), 32'h0100);
        done_count = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done === 1'b1) done_count++;
        end
        checkOutput("ignored_start_extra_done", 32'(done_count), 32'd0);
        checkOutput("ignored_start_sum_kept", 32'(bus.sum), 32'h0100);

        // Reset one cycle after accept aborts with no done and clears the results.
        applyStimulus(1'b1, 16'h1111, 16'h1111, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_sum", 32'(bus.sum), 32'd0);
        checkOutput("abort_cout", 32'(bus.cout), 32'd0);
        last_sum = '0;
        done_count = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1) done_count++;
            tick();
        end
        checkOutput("abort_no_done", 32'(done_count), 32'd0);
        runOp("after_abort", 16'h0001, 16'h0002, 1'b0, 1'b0);
        checkOutput("tp_0003", 32'(bus.sum), 32'h0003);

        for (int i = 0; i < 8; i++) begin
            runOp("random", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), SUB_EN & 1'($urandom));
        end

        // Back-to-back: start held high, next operands presented while each result completes.
        for (int i = 0; i < 6; i++) begin
            pa[i] = WIDTH'($urandom);
            pb[i] = WIDTH'($urandom);
            pc[i] = 1'($urandom);
        end
        op_drv = 1'b0;
        applyStimulus(1'b1, pa[0], pb[0], pc[0]);
        tick();
        for (int k = 0; k < 5; k++) begin
            checkOutput("b2b_busy_after_accept", 32'(bus.busy), 32'd1);
            applyStimulus(1'b1, pa[k+1], pb[k+1], pc[k+1]);
            waitDone(lat, busy_cycles);
            checkOutput("b2b_latency", 32'(lat), 32'(NIBBLES));
            checkResult("b2b", refModel(pa[k], pb[k], pc[k], 1'b0));
            tick();
        end
        checkOutput("b2b_last_accept", 32'(bus.busy), 32'd1);
        applyStimulus(1'b0, '0, '0, 1'b0);
        waitDone(lat, busy_cycles);
        checkOutput("b2b_last_latency", 32'(lat), 32'(NIBBLES));
        checkResult("b2b_last", refModel(pa[5], pb[5], pc[5], 1'b0));
        tick();

`ifdef MULTIWORD_ADD_SEQ_SUB_EN
        runOp("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1);
        checkOutput("tp_sub_fffe", 32'(bus.sum), 32'hFFFE);
        checkOutput("tp_sub_fffe_cout", 32'(bus.cout), 32'd0);
        checkOutput("tp_sub_fffe_ovf", 32'(bus.ovf), 32'd0);
        runOp("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 1'b1);
        checkOutput("tp_sub_7fff", 32'(bus.sum), 32'h7FFF);
        checkOutput("tp_sub_7fff_cout", 32'(bus.cout), 32'd1);
        checkOutput("tp_sub_7fff_ovf", 32'(bus.ovf), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
